// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake.
// Each request waits a fixed LATENCY, then returns one registered response.
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic            r_write;
    logic            r_err;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_wdata;
    logic [3:0]      r_be;
    logic [31:0]     r_mem [DEPTH_WORDS] = '{default: 32'h0};

    logic            w_req_err;
    logic            w_access;
    logic            w_mem_we;

    // Range check on the full word address; the latched index is only used when this is clear.
    assign w_req_err = (req_addr[1:0] != 2'b00) ||
                       ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign w_access  = (r_state == WAIT) && (r_cnt == 4'd0);
    assign w_mem_we  = w_access && r_write && !r_err && !rst;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_write    <= 1'b0;
            r_err      <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= 32'h0;
            r_be       <= 4'h0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write   <= req_write;
                        r_err     <= w_req_err;
                        r_idx     <= req_addr[AW+1:2];
                        r_wdata   <= req_wdata;
                        r_be      <= req_be;
                        r_cnt     <= 4'(LATENCY);
                        req_ready <= 1'b0;
                        r_state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        resp_valid <= 1'b1;
                        resp_err   <= r_err;
                        resp_rdata <= (r_write || r_err) ? 32'h0 : r_mem[r_idx];
                        r_state    <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'h0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: storage has no reset; contents survive rst and only the pending request is dropped.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (r_be[b]) begin
                    r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit storage words.
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the wait cycles between request acceptance and memory access (legal range 0-15).
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst, input, width 1: reset, asynchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, width 1: the initiator presents a request.
REQ-006 The block SHALL have port req_ready, output, width 1: the responder can accept a request.
REQ-007 The block SHALL have port req_write, input, width 1: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr, input, width 32: the byte address.
REQ-009 The block SHALL have port req_wdata, input, width 32: the store data.
REQ-010 The block SHALL have port req_be, input, width 4: store byte enables; bit i enables byte i (bits [8i+7:8i]).
REQ-011 The block SHALL have port resp_valid, output, width 1: a response is present.
REQ-012 The block SHALL have port resp_ready, input, width 1: the initiator accepts the response.
REQ-013 The block SHALL have port resp_rdata, output, width 32: the load data, signed word as stored.
REQ-014 The block SHALL have port resp_err, output, width 1: the request was misaligned or out of range.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 In IDLE, a request SHALL be accepted on a clk edge where req_valid=1; all req_* fields are then latched and the FSM enters WAIT with the wait counter set to LATENCY.
REQ-018 In WAIT, the counter SHALL decrement each edge; on the edge where the counter is 0, the access SHALL be performed and the FSM SHALL enter RESP.
REQ-019 With acceptance at edge N, resp_valid SHALL first be 1 after edge N+LATENCY+1; for LATENCY=0, this is after edge N+1.
REQ-020 A store SHALL write only the enabled bytes of word req_addr[31:2]; req_be=0 SHALL be a no-op that still receives an OK response.
REQ-021 A load SHALL return the full word on resp_rdata; req_be SHALL be ignored for loads.
REQ-022 A store response SHALL return resp_rdata=0.
REQ-023 A request is an error if req_addr[1:0]≠0 or req_addr[31:2]≥DEPTH_WORDS; an error request SHALL NOT access memory and SHALL return resp_err=1 and resp_rdata=0.
REQ-024 resp_valid, resp_rdata and resp_err SHALL be registered and held stable in RESP until an edge with resp_ready=1, after which the FSM SHALL return to IDLE.
REQ-025 No request SHALL be accepted on the same edge that a response completes; the maximum throughput SHALL be one request per LATENCY+3 cycles when resp_ready is held at 1.
REQ-026 Changes on req_* inputs outside IDLE SHALL have no effect.
REQ-027 Storage SHALL be initialised to zero at time zero and SHALL NOT be cleared by rst.

Reset
REQ-028 While rst=1, the FSM SHALL be in IDLE, req_ready SHALL be 1, resp_valid SHALL be 0, resp_rdata SHALL be 0, resp_err SHALL be 0, and the counter SHALL be 0.
REQ-029 If rst asserts during WAIT or RESP, the pending request SHALL be discarded and an uncommitted store SHALL NOT be written.
REQ-030 After rst deasserts, the first rising edge with req_valid=1 SHALL be accepted.

Verification
REQ-031 A store of 0xDEADBEEF to addr 0x10 with be=4'hF, followed by a load from 0x10 SHALL give resp_rdata=0xDEADBEEF, resp_err=0, with resp_valid first high 3 edges after acceptance (LATENCY=2).
REQ-032 With word 0x10 holding 0xDEADBEEF, a store of 0x11223344 with be=4'b0101 followed by a load SHALL give 0xDE22BE44.
REQ-033 A load from 0x12 and a load from 0x400 (DEPTH_WORDS=256) SHALL each give resp_err=1 and rdata=0, and memory SHALL be unchanged.
REQ-034 Holding resp_ready=0 for 5 cycles SHALL keep resp_valid and resp_rdata stable and req_ready=0; raising resp_ready SHALL give req_ready=1 on the following cycle.
REQ-035 Asserting rst during WAIT of a store of 0xCAFEF00D to 0x20 SHALL leave a subsequent load from 0x20 returning 0x00000000.
REQ-036 With LATENCY=0 and resp_ready=1, back-to-back requests SHALL be accepted every 3 cycles.
